// File: rtl/test_vector_sequencer.sv
// -----------------------------------------------------------------------------
// test_vector_sequencer
//
// Central control sequencer for the vector tester. For each of NUM_VECTORS
// vectors it reads SIG_WIDTH/WORD_WIDTH words from an asynchronous SRAM into a
// shadow register and drives the whole shadow onto SIGNALS in one cycle
// (through the voltage translators). It then waits SETTLE_CYCLES, parallel-loads
// the response shift chain and shifts CAP_WIDTH bits in MSB-first. Each captured
// response is offered on a valid/ready port to the UART transmit path.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   START, ABORT        run request (IDLE only), immediate stop (non-IDLE only)
//   NUM_VECTORS         number of vectors, latched on START
//   BUSY, DONE          run in progress, one-cycle end-of-run pulse
//   SRAM_ADDR/DATA      SRAM read address / read data
//   CS_BAR/OE_BAR/WE_BAR SRAM strobes (active low, WE_BAR tied high)
//   SIGNALS, VT_EN      stimulus bus to DUT, voltage translator enable
//   PL_BAR, SHCP, Q     shift chain parallel load, shift clock, serial data
//   RESULT, RESULT_VALID, RESULT_READY  captured response handshake
// -----------------------------------------------------------------------------
module test_vector_sequencer #(
    parameter int SIG_WIDTH     = 128,
    parameter int WORD_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int CAP_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int SHIFT_HALF    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] NUM_VECTORS,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    input  logic [WORD_WIDTH-1:0] SRAM_DATA,
    output logic                  CS_BAR,
    output logic                  OE_BAR,
    output logic                  WE_BAR,
    output logic [SIG_WIDTH-1:0]  SIGNALS,
    output logic                  VT_EN,
    output logic                  PL_BAR,
    output logic                  SHCP,
    input  logic                  Q,
    output logic [CAP_WIDTH-1:0]  RESULT,
    output logic                  RESULT_VALID,
    input  logic                  RESULT_READY
);

    localparam int WORDS    = SIG_WIDTH / WORD_WIDTH;
    localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int HALF_W   = (SHIFT_HALF > 1) ? $clog2(SHIFT_HALF) : 1;
    localparam int BIT_W    = (CAP_WIDTH > 1) ? $clog2(CAP_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_APPLY  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_REPORT = 3'd5
    } state_e;

    state_e                state_q,        state_d;
    logic [ADDR_WIDTH-1:0] vec_left_q,     vec_left_d;
    logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
    logic [WIDX_W-1:0]     word_q,         word_d;
    logic                  phase_q,        phase_d;   // 0: address phase, 1: data latch phase
    logic [SIG_WIDTH-1:0]  shadow_q,       shadow_d;
    logic [SIG_WIDTH-1:0]  signals_q,      signals_d;
    logic                  vt_en_q,        vt_en_d;
    logic [SETTLE_W-1:0]   settle_q,       settle_d;
    logic [HALF_W-1:0]     half_q,         half_d;
    logic [BIT_W-1:0]      bit_q,          bit_d;
    logic [CAP_WIDTH-1:0]  work_q,         work_d;
    logic [CAP_WIDTH-1:0]  result_q,       result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  cs_bar_q,       cs_bar_d;
    logic                  oe_bar_q,       oe_bar_d;
    logic                  pl_bar_q,       pl_bar_d;
    logic                  shcp_q,         shcp_d;
    logic                  busy_q,         busy_d;
    logic                  done_q,         done_d;
    logic                  abort_s;

    // ABORT only matters while a run is in progress.
    assign abort_s = ABORT && (state_q != ST_IDLE);

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_d        = state_q;
        vec_left_d     = vec_left_q;
        addr_d         = addr_q;
        word_d         = word_q;
        phase_d        = phase_q;
        shadow_d       = shadow_q;
        signals_d      = signals_q;
        vt_en_d        = vt_en_q;
        settle_d       = settle_q;
        half_d         = half_q;
        bit_d          = bit_q;
        work_d         = work_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        cs_bar_d       = cs_bar_q;
        oe_bar_d       = oe_bar_q;
        pl_bar_d       = pl_bar_q;
        shcp_d         = shcp_q;
        done_d         = 1'b0;

        if (abort_s) begin
            // Drop every strobe at once; SIGNALS and RESULT keep their values.
            state_d        = ST_IDLE;
            cs_bar_d       = 1'b1;
            oe_bar_d       = 1'b1;
            pl_bar_d       = 1'b1;
            shcp_d         = 1'b0;
            vt_en_d        = 1'b0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        vec_left_d = NUM_VECTORS;
                        addr_d     = '0;
                        if (NUM_VECTORS == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d  = ST_FETCH;
                            phase_d  = 1'b0;
                            word_d   = '0;
                            cs_bar_d = 1'b0;
                            oe_bar_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Data has had a full cycle to settle behind the address.
                        shadow_d[word_q*WORD_WIDTH +: WORD_WIDTH] = SRAM_DATA;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        phase_d = 1'b0;
                        if (word_q == WIDX_W'(WORDS - 1)) begin
                            state_d   = ST_APPLY;
                            cs_bar_d  = 1'b1;
                            oe_bar_d  = 1'b1;
                            signals_d = shadow_d;   // includes the word latched this cycle
                            vt_en_d   = 1'b1;
                            settle_d  = '0;
                        end else begin
                            word_d = word_q + WIDX_W'(1);
                        end
                    end
                end

                ST_APPLY: begin
                    // The first APPLY cycle is the one where SIGNALS changed.
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d  = ST_LOAD;
                        pl_bar_d = 1'b0;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end

                ST_LOAD: begin
                    state_d  = ST_SHIFT;
                    pl_bar_d = 1'b1;
                    shcp_d   = 1'b0;
                    half_d   = '0;
                    bit_d    = '0;
                end

                ST_SHIFT: begin
                    if (half_q == HALF_W'(SHIFT_HALF - 1)) begin
                        half_d = '0;
                        if (!shcp_q) begin
                            // Last low cycle: chain output is stable, take it.
                            work_d = CAP_WIDTH'({work_q, Q});
                            shcp_d = 1'b1;
                        end else begin
                            shcp_d = 1'b0;
                            if (bit_q == BIT_W'(CAP_WIDTH - 1)) begin
                                state_d        = ST_REPORT;
                                result_d       = work_q;
                                result_valid_d = 1'b1;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                            end
                        end
                    end else begin
                        half_d = half_q + HALF_W'(1);
                    end
                end

                ST_REPORT: begin
                    if (RESULT_READY) begin
                        result_valid_d = 1'b0;
                        if (vec_left_q == ADDR_WIDTH'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            vt_en_d = 1'b0;
                        end else begin
                            vec_left_d = vec_left_q - ADDR_WIDTH'(1);
                            state_d    = ST_FETCH;
                            phase_d    = 1'b0;
                            word_d     = '0;
                            cs_bar_d   = 1'b0;
                            oe_bar_d   = 1'b0;
                        end
                    end else begin
                        state_d = ST_REPORT;
                    end
                end

                default: begin
                    state_d        = ST_IDLE;
                    cs_bar_d       = 1'b1;
                    oe_bar_d       = 1'b1;
                    pl_bar_d       = 1'b1;
                    shcp_d         = 1'b0;
                    vt_en_d        = 1'b0;
                    result_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset to idle values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            vec_left_q     <= '0;
            addr_q         <= '0;
            word_q         <= '0;
            phase_q        <= 1'b0;
            shadow_q       <= '0;
            signals_q      <= '0;
            vt_en_q        <= 1'b0;
            settle_q       <= '0;
            half_q         <= '0;
            bit_q          <= '0;
            work_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cs_bar_q       <= 1'b1;
            oe_bar_q       <= 1'b1;
            pl_bar_q       <= 1'b1;
            shcp_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_left_q     <= vec_left_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            phase_q        <= phase_d;
            shadow_q       <= shadow_d;
            signals_q      <= signals_d;
            vt_en_q        <= vt_en_d;
            settle_q       <= settle_d;
            half_q         <= half_d;
            bit_q          <= bit_d;
            work_q         <= work_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            cs_bar_q       <= cs_bar_d;
            oe_bar_q       <= oe_bar_d;
            pl_bar_q       <= pl_bar_d;
            shcp_q         <= shcp_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign SRAM_ADDR    = addr_q;
    assign CS_BAR       = cs_bar_q;
    assign OE_BAR       = oe_bar_q;
    assign WE_BAR       = 1'b1;
    assign SIGNALS      = signals_q;
    assign VT_EN        = vt_en_q;
    assign PL_BAR       = pl_bar_q;
    assign SHCP         = shcp_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;

endmodule

// File: doc/test_vector_sequencer.md
Name: test_vector_sequencer

Overview:
- Parametrised successor to the tester's central control FSM, covering its vector play-out and capture path.
- Plays NUM_VECTORS stored stimulus vectors from SRAM onto the DUT signal bus through the voltage translators, waits a programmable settle time, then captures DUT responses through the parallel-in/serial-out shift-register chain.
- Presents each captured response on a valid/ready port to the UART transmit path.
- Generalised in bus width, SRAM word width, capture width and settle time; adds abort and backpressure, which the previous generation lacked.

Parameters:
- SIG_WIDTH, 128, width of SIGNALS to DUT; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 8, SRAM data word width.
- ADDR_WIDTH, 16, SRAM address width; also the width of the vector count.
- CAP_WIDTH, 32, number of DUT response bits shifted in per vector.
- SETTLE_CYCLES, 4, CLK cycles SIGNALS is held before capture (minimum 1).
- SHIFT_HALF, 2, CLK cycles per SHCP half-period (minimum 1).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle run request; sampled only in IDLE
- ABORT  in  1  stop run immediately
- NUM_VECTORS  in  ADDR_WIDTH  vectors to play; latched on START
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when the final result is accepted
- SRAM_ADDR  out  ADDR_WIDTH  SRAM read address
- SRAM_DATA  in  WORD_WIDTH  SRAM read data
- CS_BAR, OE_BAR, WE_BAR  out  1 each  SRAM strobes, active low; WE_BAR constant 1
- SIGNALS  out  SIG_WIDTH  stimulus to DUT
- VT_EN  out  1  voltage translator enable
- PL_BAR  out  1  shift register parallel load, active low
- SHCP  out  1  shift clock
- Q  in  1  serial data from shift chain
- RESULT  out  CAP_WIDTH  captured response
- RESULT_VALID  out  1  RESULT holds a new response
- RESULT_READY  in  1  consumer accepts RESULT

Behaviour:
- Reset values (asynchronous): state IDLE; SIGNALS 0; RESULT 0; SRAM_ADDR 0; CS_BAR/OE_BAR/WE_BAR/PL_BAR 1; SHCP, VT_EN, BUSY, DONE, RESULT_VALID 0.
- W = SIG_WIDTH/WORD_WIDTH words per vector.
- Vector v, word j is read from address v*W+j, starting at address 0. SRAM_ADDR is a linear counter that wraps modulo 2^ADDR_WIDTH.
- Word j loads shadow[j*WORD_WIDTH +: WORD_WIDTH], so word 0 is the LSB word.
- States are IDLE, FETCH, APPLY, LOAD, SHIFT, REPORT.
- IDLE:
  - START=1 latches NUM_VECTORS and clears the address counter.
  - Count 0: DONE pulses the following cycle; no SRAM access; VT_EN stays 0; remain IDLE.
  - Count nonzero: go to FETCH.
- FETCH: two cycles per word.
  - Phase A: SRAM_ADDR valid, CS_BAR=OE_BAR=0.
  - Phase B: SRAM_DATA latched into the shadow; address increments.
  - After word W-1, go to APPLY. CS_BAR/OE_BAR return to 1.
  - SIGNALS is not changed during FETCH.
- APPLY:
  - On entry, shadow is copied to SIGNALS (single-cycle whole-bus update) and VT_EN is set to 1.
  - Hold for SETTLE_CYCLES cycles, counted from the cycle SIGNALS changes, then go to LOAD.
- LOAD: PL_BAR=0 for exactly 1 cycle, then SHIFT.
- SHIFT:
  - Repeat CAP_WIDTH times: SHCP low for SHIFT_HALF cycles; sample Q on the last low cycle; then SHCP high for SHIFT_HALF cycles.
  - The first sample lands in RESULT[CAP_WIDTH-1] (MSB-first shift into a working register).
  - SHCP ends low. The working register is copied to RESULT when entering REPORT.
- REPORT:
  - RESULT_VALID=1; RESULT is held stable until RESULT_READY=1.
  - On acceptance, RESULT_VALID drops next cycle.
  - If vectors remain, go to FETCH; otherwise go to IDLE with a one-cycle DONE pulse.
  - Backpressure is unlimited; there is no timeout.
- VT_EN stays 1 between vectors of a run and drops to 0 on return to IDLE. SIGNALS holds the last vector after the run.
- ABORT:
  - Has priority over all other inputs in every non-IDLE state. Next cycle: state IDLE, CS_BAR/OE_BAR/PL_BAR=1, SHCP=0, VT_EN=0, RESULT_VALID=0, no DONE pulse. SIGNALS is held.
  - ABORT in IDLE is ignored. ABORT and START in the same IDLE cycle: START wins.
- START while BUSY is ignored.
- Latched count 2^ADDR_WIDTH-1 is legal. Address wrap is not an error.

Test Plan:
- Reset mid-SHIFT with SHCP=1 -> all outputs at reset values asynchronously, before the next CLK edge.
- Defaults, NUM_VECTORS=1, SRAM[a]=a for a=0..15, shift chain presents 0xA5A5_0F0F MSB-first:
  - SIGNALS=0x0F0E0D0C_0B0A0908_07060504_03020100 held 4 cycles before PL_BAR low.
  - 32 SHCP rising edges.
  - RESULT=0xA5A50F0F with RESULT_VALID.
  - DONE pulses 1 cycle after RESULT_READY.
- NUM_VECTORS=3, RESULT_READY held 0 for 20 cycles on vector 2:
  - RESULT stable and SHCP idle throughout.
  - SRAM addresses 0..47 read exactly once.
  - Exactly three valid/ready transfers, then one DONE.
- NUM_VECTORS=0 -> DONE one cycle after START; CS_BAR and VT_EN never change.
- ABORT during FETCH of vector 2:
  - Next cycle: BUSY=0, CS_BAR=OE_BAR=1, VT_EN=0; no DONE.
  - SIGNALS still equals vector 1.
  - A subsequent START restarts from address 0.
- START pulsed during SHIFT -> ignored; NUM_VECTORS change after START does not affect the run.
